// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer: FSM state encoding and
// the layout of one programmable table entry.
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    // Table entry field widths; the sequencer's N and REP_W default to these.
    localparam int TICKS_W = 8;
    localparam int REPS_W  = 8;

    localparam int unsigned TICKS_MIN = 1;

    typedef struct packed {
        logic [TICKS_W-1:0] ticks;
        logic [REPS_W-1:0]  reps;
    } step_t;

endpackage

// File: rtl/pulse_generator.sv
// Periodic one-clock pulse source: while enabled, pulses on every ticks_i-th
// cycle counted from the last synchronous clear.
module pulse_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [N-1:0] ticks_i,
    output logic         pulse_o
);

    logic [N-1:0] cnt_q, cnt_d;
    logic         wrap;

    assign wrap    = (cnt_q == ticks_i - N'(1));
    assign pulse_o = en_i & ~clr_i & wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + N'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Steps one shared pulse_generator through a table of {ticks, reps} entries,
// with start/busy/done handshake, abort and optional looping.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int N     = TICKS_W,
    parameter int STEPS = 4,
    parameter int REP_W = REPS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(STEPS)-1:0] cfg_addr,
    input  logic [N-1:0]             cfg_ticks,
    input  logic [REP_W-1:0]         cfg_reps,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     mode_loop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     pulse_out
);

    localparam int IDX_W = $clog2(STEPS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     ticks_q, ticks_d;
    logic [REP_W-1:0] rem_q, rem_d;
    logic             pulsed_q, pulsed_d;
    step_t            table_q [STEPS];

    step_t cur;
    logic  last_idx, later_work;
    logic  finish_entry, table_end;
    logic  gen_pulse, gen_clr, gen_en;

    assign cur      = table_q[idx_q];
    assign last_idx = (idx_q == IDX_W'(STEPS - 1));
    assign gen_en   = (state_q == RUN);
    assign gen_clr  = ~rst | (state_q != RUN);

    pulse_generator #(.N(N)) u_gen (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (gen_clr),
        .en_i    (gen_en),
        .ticks_i (ticks_q),
        .pulse_o (gen_pulse)
    );

    // Finishing an entry with only empty entries behind it ends the pass directly.
    always_comb begin
        later_work = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            if (i > int'(idx_q) && table_q[i].reps != '0) later_work = 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ticks_d      = ticks_q;
        rem_d        = rem_q;
        pulsed_d     = pulsed_q;
        finish_entry = 1'b0;
        table_end    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = LOAD;
                    idx_d    = '0;
                    pulsed_d = 1'b0;
                end
            end
            LOAD: begin
                if (cur.reps == '0) begin
                    finish_entry = 1'b1;
                    table_end    = last_idx;
                end else begin
                    state_d = RUN;
                    ticks_d = (cur.ticks < N'(TICKS_MIN)) ? N'(TICKS_MIN) : cur.ticks;
                    rem_d   = cur.reps;
                end
            end
            RUN: begin
                if (gen_pulse) begin
                    rem_d    = rem_q - 1'b1;
                    pulsed_d = 1'b1;
                    if (rem_q == REP_W'(1)) begin
                        finish_entry = 1'b1;
                        table_end    = last_idx | ~later_work;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (finish_entry) begin
            if (!table_end) begin
                state_d = LOAD;
                idx_d   = idx_q + 1'b1;
            end else if (mode_loop && pulsed_d) begin
                state_d  = LOAD;
                idx_d    = '0;
                pulsed_d = 1'b0;
            end else begin
                state_d = DONE;
            end
        end

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ticks_q  <= N'(TICKS_MIN);
            rem_q    <= '0;
            pulsed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ticks_q  <= ticks_d;
            rem_q    <= rem_d;
            pulsed_q <= pulsed_d;
        end
    end

    // NOTE: the table is a small register file, so it is reset like any other
    // state; this gives every entry a defined "skip" value from power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) begin
                table_q[i] <= '{ticks: TICKS_W'(TICKS_MIN), reps: '0};
            end
        end else if (state_q == IDLE && cfg_we) begin
            table_q[cfg_addr] <= '{ticks: cfg_ticks, reps: cfg_reps};
        end
    end

    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign done      = (state_q == DONE) && !abort;
    assign step_idx  = idx_q;
    assign pulse_out = gen_pulse & (state_q == RUN) & ~abort;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: directed and random tables compared
// cycle by cycle against a timeline model built from the table contents.
module tb_pulse_sequencer;

    localparam int N     = 8;
    localparam int STEPS = 4;
    localparam int REP_W = 8;
    localparam int IDX_W = $clog2(STEPS);
    localparam int MAXC  = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [N-1:0]     cfg_ticks = '0;
    logic [REP_W-1:0] cfg_reps = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mode_loop = 1'b0;
    logic             busy, done, pulse_out;
    logic [IDX_W-1:0] step_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    int tbl_ticks [STEPS];
    int tbl_reps  [STEPS];
    bit exp_pulse [MAXC];
    bit exp_done  [MAXC];
    bit exp_busy  [MAXC];
    int exp_idx   [MAXC];

    pulse_sequencer #(.N(N), .STEPS(STEPS), .REP_W(REP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_ticks (cfg_ticks),
        .cfg_reps  (cfg_reps),
        .start     (start),
        .abort     (abort),
        .mode_loop (mode_loop),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx),
        .pulse_out (pulse_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Timeline from the table: each visited entry costs one LOAD cycle, then
    // reps periods of max(ticks,1) cycles ending in a pulse. Empty entries past
    // the last non-empty one are not visited unless the whole table is empty.
    task automatic build_model(input bit loop, input int horizon);
        int t, last, p;
        bit any;
        for (int c = 0; c < MAXC; c++) begin
            exp_pulse[c] = 1'b0;
            exp_done[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_idx[c]   = -1;
        end
        last = -1;
        for (int i = 0; i < STEPS; i++) if (tbl_reps[i] != 0) last = i;
        any = (last >= 0);
        if (!any) last = STEPS - 1;
        t = 1;
        while (t < horizon) begin
            for (int i = 0; i <= last && t < horizon; i++) begin
                exp_busy[t] = 1'b1;
                exp_idx[t]  = i;
                t++;
                p = (tbl_ticks[i] == 0) ? 1 : tbl_ticks[i];
                for (int r = 0; r < tbl_reps[i]; r++) begin
                    for (int k = 0; k < p; k++) begin
                        if (t < horizon) begin
                            exp_busy[t]  = 1'b1;
                            exp_idx[t]   = i;
                            exp_pulse[t] = (k == p - 1);
                            t++;
                        end
                    end
                end
            end
            if (!(loop && any)) begin
                if (t < horizon) exp_done[t] = 1'b1;
                break;
            end
        end
    endtask

    task automatic write_entry(input int idx, input int tk, input int rp);
        @(posedge clk); #1;
        cfg_we    = 1'b1;
        cfg_addr  = IDX_W'(idx);
        cfg_ticks = N'(tk);
        cfg_reps  = REP_W'(rp);
        tbl_ticks[idx] = tk;
        tbl_reps[idx]  = rp;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Start at cycle 0, optionally abort / write the active entry at given cycles,
    // and compare every output each cycle; returns the first observed done cycle.
    task automatic run_seq(input bit loop, input int ncyc, input int abort_at,
                           input int we_at, output int obs_done);
        build_model(loop, ncyc);
        if (abort_at >= 0) begin
            for (int c = abort_at; c < ncyc; c++) begin
                exp_pulse[c] = 1'b0;
                exp_done[c]  = 1'b0;
                if (c > abort_at) begin
                    exp_busy[c] = 1'b0;
                    exp_idx[c]  = 0;
                end
            end
        end
        obs_done  = -1;
        mode_loop = loop;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start  = (c == 0);
            abort  = (c == abort_at);
            cfg_we = (c == we_at);
            if (c == we_at) begin
                cfg_addr  = IDX_W'(exp_idx[c]);
                cfg_ticks = N'(1);
                cfg_reps  = REP_W'(9);
            end
            @(negedge clk);
            check("pulse_out", c, 32'(pulse_out), 32'(exp_pulse[c]));
            check("done", c, 32'(done), 32'(exp_done[c]));
            check("busy", c, 32'(busy), 32'(exp_busy[c]));
            if (exp_idx[c] >= 0) check("step_idx", c, 32'(step_idx), 32'(exp_idx[c]));
            if (done === 1'b1 && obs_done < 0) obs_done = c;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        abort  = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        int d;
        for (int i = 0; i < STEPS; i++) begin
            tbl_ticks[i] = 1;
            tbl_reps[i]  = 0;
        end

        // Reset state
        #12;
        check("rst_busy", 0, 32'(busy), 0);
        check("rst_done", 0, 32'(done), 0);
        check("rst_pulse", 0, 32'(pulse_out), 0);
        check("rst_idx", 0, 32'(step_idx), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Two-entry sequence: pulses 4, 7, 13, done 14
        write_entry(0, 3, 2);
        write_entry(1, 5, 1);
        run_seq(1'b0, 18, -1, -1, d);
        check("seq_done_cycle", 0, 32'(d), 14);

        // ticks=0 clamps to 1: pulses 2, 3, 4, done 5
        write_entry(0, 0, 3);
        write_entry(1, 1, 0);
        run_seq(1'b0, 8, -1, -1, d);
        check("clamp_done_cycle", 0, 32'(d), 5);

        // Looping 0,1,0,1 then abort on a pulse cycle
        write_entry(0, 2, 1);
        write_entry(1, 2, 1);
        run_seq(1'b1, 20, 15, -1, d);
        check("loop_no_done", 0, 32'(d), 32'hFFFF_FFFF);

        // start together with abort stays idle
        run_seq(1'b0, 4, 0, -1, d);
        check("start_abort_no_done", 0, 32'(d), 32'hFFFF_FFFF);

        // Empty table with looping: visits every entry, then done at STEPS+1
        write_entry(0, 1, 0);
        write_entry(1, 1, 0);
        run_seq(1'b1, 8, -1, -1, d);
        check("empty_done_cycle", 0, 32'(d), STEPS + 1);

        // Table write during RUN is ignored, now and on the next run
        write_entry(0, 4, 2);
        run_seq(1'b0, 14, -1, 3, d);
        check("we_run_done_cycle", 0, 32'(d), 10);
        run_seq(1'b0, 14, -1, -1, d);
        check("we_run_table_kept", 0, 32'(d), 10);

        // Random tables
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < STEPS; i++) begin
                write_entry(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            end
            if (it % 3 == 2) run_seq(1'b1, 48, 40, -1, d);
            else             run_seq(1'b0, 64, -1, -1, d);
        end

        // Asynchronous reset in the middle of RUN
        write_entry(0, 3, 2);
        write_entry(1, 5, 1);
        mode_loop = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_busy", 0, 32'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_busy", 0, 32'(busy), 0);
        check("async_rst_done", 0, 32'(done), 0);
        check("async_rst_pulse", 0, 32'(pulse_out), 0);
        check("async_rst_idx", 0, 32'(step_idx), 0);
        for (int i = 0; i < STEPS; i++) begin
            tbl_ticks[i] = 1;
            tbl_reps[i]  = 0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_idle_busy", c, 32'(busy), 0);
            check("post_rst_idle_pulse", c, 32'(pulse_out), 0);
        end
        run_seq(1'b0, 8, -1, -1, d);
        check("post_rst_done_cycle", 0, 32'(d), STEPS + 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Controller that sequences one shared pulse_generator through a programmable table of STEPS entries. Each entry holds a period in clocks and a repeat count. The block runs the entries in order, emits the generator's pulses, and reports progress with a start/busy/done handshake. It sits between the user-input front end of the etch-a-sketch and the timing datapath, and provides rate-varying step pulses, for example cursor acceleration profiles.

Parameters:
N, 8, width of the period (ticks) field; passed to the pulse_generator instance
STEPS, 4, number of table entries; must be at least 2
REP_W, 8, width of the repeat-count field

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
cfg_we  in  1  table write strobe; honoured only in IDLE
cfg_addr  in  $clog2(STEPS)  table entry index
cfg_ticks  in  N  period in clocks for the entry
cfg_reps  in  REP_W  number of pulses for the entry
start  in  1  begin a sequence (sampled in IDLE)
abort  in  1  cancel the sequence
mode_loop  in  1  restart at entry 0 after the last entry instead of finishing
busy  out  1  high from the cycle after start until the return to IDLE
done  out  1  one-cycle pulse at normal completion
step_idx  out  $clog2(STEPS)  index of the active entry
pulse_out  out  1  sequenced pulse, one clock wide

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; busy=0, done=0, pulse_out=0, step_idx=0.
  - All table entries reset to ticks=1, reps=0.
  - Generator counter held clear.
- States and transitions:
  - IDLE:
    - cfg_we writes entry cfg_addr.
    - start=1 and abort=0 -> LOAD with step_idx=0.
  - LOAD (1 cycle):
    - Latch the entry into active_ticks and remaining.
    - A ticks value of 0 is clamped to 1.
    - If reps=0, skip the entry: advance to the next entry and stay in LOAD, or take the end-of-table path.
    - Otherwise -> RUN.
  - RUN:
    - Generator enabled with active_ticks.
    - On each generator pulse, remaining decrements.
    - The pulse that brings remaining to 0 also advances: next entry -> LOAD, or the end-of-table path.
  - End of table, mode_loop=1, at least one pulse emitted in this pass: -> LOAD with step_idx=0. busy stays 1.
  - End of table, otherwise (mode_loop=0, or a pass with no pulses): -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Generator control:
  - Generator sync clear = ~rst | (state != RUN).
  - Each entry therefore starts from count 0.
  - First pulse of an entry occurs on the active_ticks-th RUN cycle. Subsequent pulses follow every active_ticks cycles.
  - Periods of 1 give a pulse every RUN cycle.
- Outputs:
  - pulse_out = generator out & (state==RUN) & ~abort.
  - busy=1 in LOAD and RUN.
  - done and pulse_out are never high together.
- Latency:
  - start sampled in cycle 0; LOAD in cycle 1; RUN from cycle 2.
  - First pulse in cycle 1+ticks.
  - Between entries there is one LOAD cycle plus one cycle per skipped entry.
- abort:
  - Has highest priority in every state.
  - Next state is IDLE, no done pulse, step_idx -> 0, and no pulse in the abort cycle.
  - Table contents are kept.
- Simultaneous events:
  - start with abort in IDLE: remain in IDLE.
  - start while busy: ignored.
  - cfg_we while not IDLE: ignored.
- Width and wrap rules:
  - remaining is REP_W bits and never wraps; it advances at 1 -> 0.
  - step_idx wraps only through the end-of-table path.

Decomposition:
- Shared package pulse_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE)
  - step_t struct {ticks, reps}
  - constant TICKS_MIN=1
- Instantiate pulse_generator #(.N(N)) as the single sub-module. The remaining logic (table, FSM, counters) stays in pulse_sequencer.

Test Plan:
- Reset mid-RUN: assert rst low asynchronously -> busy, done, pulse_out and step_idx go to 0 immediately. After release, only a fresh start restarts the sequence.
- Program entry 0={ticks=3,reps=2}, entry 1={ticks=5,reps=1}, other entries reps=0; start at cycle 0 -> pulses at cycles 4, 7, 13; done at cycle 14; busy 1 over cycles 1-13.
- Entry 0={ticks=0,reps=3}, rest reps=0 -> 0 is clamped to 1: pulses at cycles 2, 3, 4; done at cycle 5.
- Entries 0 and 1={ticks=2,reps=1}, mode_loop=1 -> pulses repeat with step_idx cycling 0,1,0,1. Assert abort for 1 cycle -> IDLE next cycle, no done, no pulse in the abort cycle.
- All entries reps=0, mode_loop=1, start -> LOAD visits all STEPS entries with no pulse, then DONE; done at cycle STEPS+1, no hang.
- cfg_we during RUN targeting the active entry -> table unchanged, and the sequence timing matches the programmed values.
